wb_stream_prefetch: RTL
=======================

Name: wb_stream_prefetch

Overview:
Parametrised successor to the sequential-address streamer: a read-only streaming Wishbone bridge that generates sequential block-device addresses and prefetches data into a small FIFO ahead of demand.
- Slave-side reads are served from the FIFO with one-cycle latency, decoupling the streaming consumer (SPI/readout path) from block-device latency.
- Supports classic and pipelined master modes, configurable address window and step, synchronous flush/rewind, and wrap indication.

Parameters:
WIDTH, 8, data width.
WBITS, 10, address width.
START, 0, first address of the window.
LAST, START+(1<<WBITS)-1, last address; window wraps LAST->START.
STEP, 1, address increment, modulo 2^WBITS.
FBITS, 2, log2 FIFO depth (depth D = 1<<FBITS, D >= 2).
PIPED, 1, 1 = pipelined master (multiple outstanding), 0 = classic (stb held until ack).
DELAY, 3, simulation register delay.

Ports:
clk_i  in  1  system clock.
rst_i  in  1  reset, asynchronous, active-high.
flush_i  in  1  synchronous: discard FIFO and rewind address to START.
m_cyc_o  out  1  master cycle.
m_stb_o  out  1  master strobe.
m_we_o  out  1  tied 0.
m_ack_i  in  1  master ack; data valid.
m_wat_i  in  1  master wait (stall).
m_adr_o  out  WBITS  next read address.
m_dat_i  in  WIDTH  read data.
s_cyc_i  in  1  slave cycle; enables prefetching.
s_stb_i  in  1  slave strobe.
s_we_i  in  1  slave write (no effect).
s_ack_o  out  1  slave ack, registered.
s_wat_o  out  1  slave wait; high when FIFO empty.
s_dat_o  out  WIDTH  slave read data, registered.
wrap_o  out  1  one-cycle pulse when m_adr_o wraps LAST->START.

Behaviour:
- Reset (async, any cycle): m_cyc_o=0, m_stb_o=0, m_adr_o=START, s_ack_o=0, s_dat_o=0, wrap_o=0, FIFO empty, outstanding=0, state=IDLE.
- Request accepted when m_stb_o && !m_wat_i (PIPED=1); in PIPED=0, accepted on m_ack_i while m_stb_o is high.
- On accept: m_adr_o <= (m_adr_o==LAST) ? START : m_adr_o+STEP; wrap_o pulses on the LAST->START transition.
- Credit rule: m_stb_o asserted only when fifo_count + outstanding < D. The FIFO therefore never overflows, and acks are always written.
- outstanding width: FBITS+1. It increments on accept and decrements on m_ack_i; both in the same cycle leave it unchanged.
- PIPED=0: outstanding is never > 1; m_stb_o stays high until m_ack_i.
- FSM:
  - IDLE: cyc=0. Enters FETCH when s_cyc_i && !flush_i.
  - FETCH: cyc=1, stb per the credit rule. s_cyc_i low -> DRAIN. flush_i -> FLUSH.
  - DRAIN: stb=0, cyc=1. Acks still fill the FIFO. Exits to IDLE when outstanding==0, or to FETCH if s_cyc_i returns.
  - FLUSH: stb=0, cyc=1. FIFO cleared and m_adr_o=START on entry. Acks are discarded. Exits to IDLE when outstanding==0.
- flush_i in IDLE: clears the FIFO and rewinds m_adr_o the next cycle; state stays IDLE.
- FIFO contents are retained across DRAIN/IDLE, so the stream resumes exactly where it stopped.
- Slave read: s_cyc_i && s_stb_i && !s_we_i && FIFO non-empty -> pop. s_ack_o=1 and s_dat_o=head on the next cycle.
- Slave read with FIFO empty: s_wat_o=1 (combinational), no ack; retried each cycle.
- Slave write: acked next cycle, no data effect.
- Slave request during flush_i: not acked in that cycle.
- Push and pop in the same cycle: count unchanged. Push into an empty FIFO is poppable the following cycle, not the same cycle.
- Max throughput: one word per cycle in PIPED=1 with a zero-wait device.

Decomposition:
- Package tartcfg-side constants: FSM state encodings (IDLE, FETCH, DRAIN, FLUSH) and the `__WB_CLASSIC` to PIPED default mapping.
- One sub-module: stream_fifo, a synchronous FIFO of width WIDTH and depth 1<<FBITS, with push, pop, clear, count, empty and full.

Test Plan:
- Reset mid-FETCH with 3 outstanding -> m_cyc_o=0, m_adr_o=START immediately; late acks are ignored and the FIFO stays empty.
- PIPED=1, D=4, zero-wait device, s_cyc_i held, no slave reads -> exactly 4 requests (adr 0..3), then stb=0. The FIFO holds 0..3 and m_adr_o=4.
- WBITS=3, START=2, LAST=7, STEP=1, continuous slave reads -> s_dat_o sequence 2..7,2,3; wrap_o pulses once per pass.
- PIPED=0, device acks 2 cycles after stb -> stb held until ack; never more than 1 outstanding; data in order.
- flush_i with 2 outstanding -> state FLUSH, acked data discarded, then IDLE. The next stream starts at START.
- Slave read on an empty FIFO -> s_wat_o=1, no ack. The first m_ack_i gives s_ack_o one cycle after the following read.

Source files
------------

// File: rtl/wb_stream_prefetch_pkg.sv
// Shared FSM encoding and build-time defaults for the Wishbone stream prefetcher.
package wb_stream_prefetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    // Builds targeting a classic-only bus fabric default to the held-strobe master.
`ifdef __WB_CLASSIC
    localparam bit PIPED_DEFAULT = 1'b0;
`else
    localparam bit PIPED_DEFAULT = 1'b1;
`endif

endpackage

// File: rtl/wb_stream_prefetch_stream_fifo.sv
// Synchronous FIFO, depth 1<<FBITS; a pushed word is visible at the head the cycle after the push.
// Pushes are dropped when full (unless a pop frees the slot), pops ignored when empty; clear wins.
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int FBITS = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [FBITS:0]   count_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int D = 1 << FBITS;

    logic [WIDTH-1:0] mem_q [D];
    logic [FBITS-1:0] wr_q, rd_q;
    logic [FBITS:0]   cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (FBITS+1)'(D));
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{FBITS{1'b0}}, do_push} - {{FBITS{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wr_q] <= push_dat_i;
    end

endmodule

// File: rtl/wb_stream_prefetch.sv
// Read-only Wishbone streamer: walks an address window and prefetches into a FIFO; slave reads ack one cycle later.
// Master strobe is credit-limited by FIFO space; slave sees s_wat_o while the FIFO is empty.
module wb_stream_prefetch
    import wb_stream_prefetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WBITS = 10,
    parameter int START = 0,
    parameter int LAST  = START + (1 << WBITS) - 1,
    parameter int STEP  = 1,
    parameter int FBITS = 2,
    parameter int PIPED = int'(PIPED_DEFAULT)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    output logic             m_cyc_o,
    output logic             m_stb_o,
    output logic             m_we_o,
    input  logic             m_ack_i,
    input  logic             m_wat_i,
    output logic [WBITS-1:0] m_adr_o,
    input  logic [WIDTH-1:0] m_dat_i,
    input  logic             s_cyc_i,
    input  logic             s_stb_i,
    input  logic             s_we_i,
    output logic             s_ack_o,
    output logic             s_wat_o,
    output logic [WIDTH-1:0] s_dat_o,
    output logic             wrap_o
);
    localparam int D = 1 << FBITS;
    localparam logic [WBITS-1:0] START_A = WBITS'(START);
    localparam logic [WBITS-1:0] LAST_A  = WBITS'(LAST);
    localparam logic [WBITS-1:0] STEP_A  = WBITS'(STEP);

    state_e           state_q, state_d;
    logic [WBITS-1:0] adr_q, adr_d;
    logic [FBITS:0]   out_q, out_d;
    logic             ack_q, ack_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic             wrap_q, wrap_d;

    logic [FBITS:0]   fifo_count;
    logic             fifo_empty, fifo_full;
    logic [WIDTH-1:0] fifo_head;
    logic             credit_ok, stb, accept, ack_take, push, pop;

    // Words in the FIFO plus words in flight must always fit, so every ack has a slot.
    assign credit_ok = !fifo_full && (({1'b0, fifo_count} + {1'b0, out_q}) < (FBITS+2)'(D));
    assign stb       = (state_q == ST_FETCH) && credit_ok && !flush_i;
    assign accept    = (PIPED != 0) ? (stb && !m_wat_i) : (stb && m_ack_i);
    assign ack_take  = (PIPED != 0) ? (m_ack_i && (out_q != '0)) : accept;
    assign push      = ack_take && !flush_i && (state_q != ST_FLUSH);
    assign pop       = s_cyc_i && s_stb_i && !s_we_i && !fifo_empty && !flush_i;

    always_comb begin
        state_d = state_q;
        m_cyc_o = (state_q != ST_IDLE);
        m_stb_o = stb;
        unique case (state_q)
            ST_IDLE:  if (s_cyc_i && !flush_i) state_d = ST_FETCH;
            ST_FETCH: begin
                if (flush_i)       state_d = ST_FLUSH;
                else if (!s_cyc_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (flush_i)             state_d = ST_FLUSH;
                else if (s_cyc_i)        state_d = ST_FETCH;
                else if (out_q == '0)    state_d = ST_IDLE;
            end
            ST_FLUSH: if (out_q == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        adr_d  = adr_q;
        if (flush_i)     adr_d = START_A;
        else if (accept) adr_d = (adr_q == LAST_A) ? START_A : adr_q + STEP_A;
        out_d  = out_q + {{FBITS{1'b0}}, accept} - {{FBITS{1'b0}}, ack_take};
        wrap_d = accept && (adr_q == LAST_A);
        ack_d  = pop || (s_cyc_i && s_stb_i && s_we_i && !flush_i);
        dat_d  = pop ? fifo_head : dat_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            adr_q   <= START_A;
            out_q   <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            out_q   <= out_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            wrap_q  <= wrap_d;
        end
    end

    stream_fifo #(.WIDTH(WIDTH), .FBITS(FBITS)) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (flush_i),
        .push_i     (push),
        .push_dat_i (m_dat_i),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    assign m_we_o  = 1'b0;
    assign m_adr_o = adr_q;
    assign s_ack_o = ack_q;
    assign s_dat_o = dat_q;
    assign s_wat_o = fifo_empty;
    assign wrap_o  = wrap_q;

endmodule
